// File: rtl/coin_return_dispenser.sv
// Coin-return payout engine: greedy largest-first dispensing with valid/ack hopper handshake.
// Optional per-coin inventory tracking is enabled by defining COIN_INVENTORY_EN.
module coin_return_dispenser #(
    parameter int NUM_COINS   = 3,
    parameter int TOTAL_BITS  = 31,
    parameter int COIN0_VALUE = 100,
    parameter int COIN1_VALUE = 500,
    parameter int COIN2_VALUE = 1000,
    parameter int ACK_TIMEOUT = 16
`ifdef COIN_INVENTORY_EN
    ,
    parameter int STOCK_BITS  = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_return_req,
    input  logic [TOTAL_BITS-1:0] i_return_amount,
    output logic [NUM_COINS-1:0]  o_coin_valid,
    input  logic                  i_coin_ack,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_residual,
    output logic                  o_fault
`ifdef COIN_INVENTORY_EN
    ,
    input  logic [NUM_COINS-1:0]  i_restock
`endif
);

    localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_OFFER, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [TOTAL_BITS-1:0]  remaining_q, remaining_d;
    logic [TOTAL_BITS-1:0]  residual_q, residual_d;
    logic [IDX_W-1:0]       coin_idx_q, coin_idx_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                   fault_q, fault_d;
    logic [NUM_COINS-1:0]   avail;
    logic                   found;
    logic [IDX_W-1:0]       sel_idx;

    function automatic logic [TOTAL_BITS-1:0] coin_value(input int k);
        case (k)
            0:       coin_value = TOTAL_BITS'(COIN0_VALUE);
            1:       coin_value = TOTAL_BITS'(COIN1_VALUE);
            2:       coin_value = TOTAL_BITS'(COIN2_VALUE);
            default: coin_value = '0;
        endcase
    endfunction

`ifdef COIN_INVENTORY_EN
    logic [NUM_COINS-1:0][STOCK_BITS-1:0] stock_q, stock_d;
    logic                                 ack_fire;

    assign ack_fire = (state_q == S_OFFER) && i_coin_ack;

    // Restock and payout of the same coin in one cycle cancel out.
    always_comb begin
        stock_d = stock_q;
        avail   = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            avail[k] = (stock_q[k] != '0);
            if (i_restock[k] && !(ack_fire && coin_idx_q == IDX_W'(k))) begin
                if (stock_q[k] != '1) stock_d[k] = stock_q[k] + 1'b1;
            end else if (!i_restock[k] && ack_fire && coin_idx_q == IDX_W'(k)) begin
                stock_d[k] = stock_q[k] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) stock_q <= '0;
        else          stock_q <= stock_d;
    end
`else
    assign avail = '1;
`endif

    // Coin values ascend with index, so the last qualifying index is the largest coin.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (coin_value(k) != '0 && coin_value(k) <= remaining_q && avail[k]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            residual_q  <= '0;
            coin_idx_q  <= '0;
            tmo_cnt_q   <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            residual_q  <= residual_d;
            coin_idx_q  <= coin_idx_d;
            tmo_cnt_q   <= tmo_cnt_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        residual_d  = residual_q;
        coin_idx_d  = coin_idx_q;
        tmo_cnt_d   = tmo_cnt_q;
        fault_d     = fault_q;
        case (state_q)
            S_IDLE: begin
                if (i_return_req) begin
                    remaining_d = i_return_amount;
                    fault_d     = 1'b0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (found) begin
                    coin_idx_d = sel_idx;
                    tmo_cnt_d  = '0;
                    state_d    = S_OFFER;
                end else begin
                    residual_d = remaining_q;
                    state_d    = S_DONE;
                end
            end
            S_OFFER: begin
                if (i_coin_ack) begin
                    remaining_d = remaining_q - coin_value(int'(coin_idx_q));
                    state_d     = S_SELECT;
                end else if (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    fault_d    = 1'b1;
                    residual_d = remaining_q;
                    state_d    = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_coin_valid = '0;
        for (int k = 0; k < NUM_COINS; k++)
            o_coin_valid[k] = (state_q == S_OFFER) && (coin_idx_q == IDX_W'(k));
        o_busy     = (state_q != S_IDLE);
        o_done     = (state_q == S_DONE);
        o_residual = residual_q;
        o_fault    = fault_q;
    end

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Bench for coin_return_dispenser: directed cases plus random payouts against a greedy model.
module tb_coin_return_dispenser;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_return_req;
    logic [30:0] i_return_amount;
    logic [2:0]  o_coin_valid;
    logic        i_coin_ack;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_residual;
    logic        o_fault;
`ifdef COIN_INVENTORY_EN
    logic [2:0]  i_restock;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int unsigned cval [3] = '{100, 500, 1000};
    int mstock [3] = '{0, 0, 0};
`ifdef COIN_INVENTORY_EN
    bit unlimited = 1'b0;
`else
    bit unlimited = 1'b1;
`endif

    coin_return_dispenser dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_return_req    (i_return_req),
        .i_return_amount (i_return_amount),
        .o_coin_valid    (o_coin_valid),
        .i_coin_ack      (i_coin_ack),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_residual      (o_residual),
        .o_fault         (o_fault)
`ifdef COIN_INVENTORY_EN
        ,
        .i_restock       (i_restock)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Request a payout and service the hopper side; expectations come from a greedy model.
    task automatic do_payout(input logic [30:0] amt, input int ack_dly, input bit exp_tmo,
                             input int busy_amt, input bit rnd_ack);
        int          exp_coin[$];
        int          stk[3];
        logic [30:0] rem;
        logic [30:0] exp_res;
        int          lat, held, noff;
        bit          in_offer, got_done;
        logic [2:0]  cur;

        stk = mstock;
        rem = amt;
        for (int k = 2; k >= 0; k--) begin
            while (rem >= cval[k] && (unlimited || stk[k] > 0)) begin
                exp_coin.push_back(k);
                rem = rem - cval[k];
                stk[k]--;
            end
        end
        if (exp_tmo) begin
            while (exp_coin.size() > 1) void'(exp_coin.pop_back());
            exp_res = amt;
        end else begin
            exp_res = rem;
            if (!unlimited) mstock = stk;
        end

        i_return_req    = 1'b1;
        i_return_amount = amt;
        lat = 0; held = 0; noff = 0; in_offer = 0; got_done = 0; cur = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            i_return_req = 1'b0;
            i_coin_ack   = 1'b0;
            lat++;
            if (o_done) begin
                got_done = 1'b1;
                break;
            end
            if (lat == 1 && !in_offer) begin
                chk("busy_select", o_busy, 1'b1);
                if (noff == 0 && busy_amt >= 0) begin
                    i_return_req    = 1'b1;
                    i_return_amount = 31'(busy_amt);
                end
                if (rnd_ack) i_coin_ack = 1'($urandom_range(0, 1));
            end
            if (!in_offer && o_coin_valid != 3'b000) begin
                chk("coin_latency", lat, 2);
                if (noff < exp_coin.size())
                    chk("coin_onehot", o_coin_valid, 3'b001 << exp_coin[noff]);
                else
                    chk("coin_count", noff + 1, exp_coin.size());
                cur = o_coin_valid;
                noff++;
                in_offer = 1'b1;
                held = 0;
            end
            if (in_offer) begin
                chk("valid_stable", o_coin_valid, cur);
                if (held == ack_dly) begin
                    i_coin_ack = 1'b1;
                    lat = 0;
                    in_offer = 1'b0;
                end else begin
                    held++;
                end
            end
        end
        i_return_req = 1'b0;
        i_coin_ack   = 1'b0;
        chk("done_seen", got_done, 1'b1);
        if (got_done) begin
            chk("done_coins", noff, exp_coin.size());
            chk("done_residual", o_residual, exp_res);
            chk("done_fault", o_fault, exp_tmo);
            chk("done_busy", o_busy, 1'b1);
            if (exp_tmo) chk("tmo_cycles", held, 16);
            else         chk("done_latency", lat, 2);
            @(negedge clk);
            chk("done_pulse", o_done, 1'b0);
            chk("idle_busy", o_busy, 1'b0);
            chk("residual_hold", o_residual, exp_res);
        end
    endtask

`ifdef COIN_INVENTORY_EN
    task automatic restock(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            i_restock = 3'b001 << k;
            @(negedge clk);
            if (mstock[k] < 255) mstock[k]++;
        end
        i_restock = '0;
    endtask
`endif

    initial begin
        reset_n         = 1'b0;
        i_return_req    = 1'b0;
        i_return_amount = '0;
        i_coin_ack      = 1'b0;
`ifdef COIN_INVENTORY_EN
        i_restock       = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_valid", o_coin_valid, 3'b000);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_residual", o_residual, 31'd0);
        chk("rst_fault", o_fault, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef COIN_INVENTORY_EN
        restock(1, 1);
        restock(0, 2);
        do_payout(31'd1600, 1, 1'b0, -1, 1'b0);
        for (int k = 0; k < 3; k++) restock(k, 250);
`endif

        do_payout(31'd1600, 1, 1'b0, -1, 1'b0);
        do_payout(31'd0, 1, 1'b0, -1, 1'b0);
        do_payout(31'd1250, 0, 1'b0, -1, 1'b0);
        do_payout(31'd150, 2, 1'b0, -1, 1'b0);

        // Reset while a coin is on offer: everything clears and no done appears.
        i_return_req    = 1'b1;
        i_return_amount = 31'd1600;
        @(negedge clk);
        i_return_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_offer", o_coin_valid, 3'b100);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_valid", o_coin_valid, 3'b000);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_done", o_done, 1'b0);
        chk("midrst_residual", o_residual, 31'd0);
        chk("midrst_fault", o_fault, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_done", o_done, 1'b0);
        end

        do_payout(31'd500, 0, 1'b0, 1000, 1'b0);
        do_payout(31'd500, 1000, 1'b1, -1, 1'b0);
        repeat (3) @(negedge clk);
        chk("fault_sticky", o_fault, 1'b1);
        do_payout(31'd500, 0, 1'b0, -1, 1'b0);

        for (int t = 0; t < 20; t++)
            do_payout(31'($urandom_range(0, 5000)), int'($urandom_range(0, 3)), 1'b0, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
